// File: rtl/pwm_capture.sv
// Purpose : measure high time and rise-to-rise period of an external PWM/servo pin in prescaler ticks.
// Latency : valid pulses in the cycle after the 3rd CLK rising edge following the closing pin rise.
// Backpres: none; valid is a one-cycle strobe, and duty/period hold until the next measurement.
//
// Ports:
//   CLK, CPU_RESETN   system clock, asynchronous active-low reset
//   pwm_in            asynchronous PWM pin
//   duty, period      last measured high time / period, in ticks (saturating)
//   valid             one-cycle strobe when duty/period update
//   in_range          DUTYLOW <= duty <= DUTYHIGH for the published measurement
//   locked            at least one measurement since reset or signal loss
//   signal_lost       no edge seen for TIMEOUT_TICKS ticks, and no measurement since
module pwm_capture #(
    parameter int DUTYLOW       = 52,
    parameter int DUTYHIGH      = 102,
    parameter int DUTYWIDTH     = 10,
    parameter int PERWIDTH      = 12,
    parameter int TICK_DIV      = 1947,   // must be >= 2
    parameter int TIMEOUT_TICKS = 2048
) (
    input  logic                 CLK,
    input  logic                 CPU_RESETN,
    input  logic                 pwm_in,
    output logic [DUTYWIDTH-1:0] duty,
    output logic [PERWIDTH-1:0]  period,
    output logic                 valid,
    output logic                 in_range,
    output logic                 locked,
    output logic                 signal_lost
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int IW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0]        TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [IW-1:0]        IDLE_LIMIT = IW'(TIMEOUT_TICKS);
    localparam logic [DUTYWIDTH-1:0] DUTY_LO    = DUTYWIDTH'(DUTYLOW);
    localparam logic [DUTYWIDTH-1:0] DUTY_HI    = DUTYWIDTH'(DUTYHIGH);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_HIGH, S_LOW} state_t;

    state_t               state_q, state_d;
    logic                 sync_meta, sync_q, hist_q;
    logic                 rise, fall, tick, timeout;
    logic [TW-1:0]        tick_cnt;
    logic [IW-1:0]        idle_cnt;
    logic [DUTYWIDTH-1:0] hi_cnt, width_hold;
    logic [PERWIDTH-1:0]  per_cnt;
    logic                 clr_cnt, capture, publish, cnt_hi, cnt_per;

    // Two-flop synchronizer plus one history flop for edge detection.
    always_ff @(posedge CLK or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            hist_q    <= 1'b0;
        end else begin
            sync_meta <= pwm_in;
            sync_q    <= sync_meta;
            hist_q    <= sync_q;
        end
    end

    assign rise = sync_q & ~hist_q;
    assign fall = ~sync_q & hist_q;

    // Free-running tick divider, deliberately independent of the pin so the
    // tick base matches the generator's prescaler.
    always_ff @(posedge CLK or negedge CPU_RESETN) begin
        if (!CPU_RESETN)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + TW'(1);
    end

    assign tick = (tick_cnt == TICK_LAST);

    // Ticks since the last edge; saturates at the limit so a stuck line keeps
    // the timeout asserted.
    always_ff @(posedge CLK or negedge CPU_RESETN) begin
        if (!CPU_RESETN)
            idle_cnt <= '0;
        else if (rise || fall)
            idle_cnt <= '0;
        else if (tick && (idle_cnt != IDLE_LIMIT))
            idle_cnt <= idle_cnt + IW'(1);
    end

    // An edge in the same cycle proves the signal is back, so it suppresses
    // the timeout; otherwise the first edge after a loss would be swallowed.
    assign timeout = (idle_cnt == IDLE_LIMIT) && !(rise || fall);

    // State register
    always_ff @(posedge CLK or negedge CPU_RESETN) begin
        if (!CPU_RESETN)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (fall) state_d = S_ARM;
                S_ARM:   if (rise) state_d = S_HIGH;
                S_HIGH:  if (fall) state_d = S_LOW;
                S_LOW:   if (rise) state_d = S_HIGH;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output decode
    always_comb begin
        clr_cnt = 1'b0;
        capture = 1'b0;
        publish = 1'b0;
        cnt_hi  = 1'b0;
        cnt_per = 1'b0;
        if (!timeout) begin
            case (state_q)
                S_ARM: clr_cnt = rise;
                S_HIGH: begin
                    capture = fall;
                    cnt_hi  = 1'b1;
                    cnt_per = 1'b1;
                end
                S_LOW: begin
                    clr_cnt = rise;
                    publish = rise;
                    cnt_per = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Measurement counters: clear on the qualifying rise beats a coincident tick.
    always_ff @(posedge CLK or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            hi_cnt     <= '0;
            per_cnt    <= '0;
            width_hold <= '0;
        end else begin
            if (clr_cnt) begin
                hi_cnt  <= '0;
                per_cnt <= '0;
            end else if (tick) begin
                if (cnt_hi && !(&hi_cnt))
                    hi_cnt <= hi_cnt + DUTYWIDTH'(1);
                if (cnt_per && !(&per_cnt))
                    per_cnt <= per_cnt + PERWIDTH'(1);
            end
            if (capture)
                width_hold <= hi_cnt;
        end
    end

    // Published results; duty/period/in_range hold through a signal loss.
    always_ff @(posedge CLK or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            duty        <= '0;
            period      <= '0;
            valid       <= 1'b0;
            in_range    <= 1'b0;
            locked      <= 1'b0;
            signal_lost <= 1'b0;
        end else begin
            valid <= publish;
            if (publish) begin
                duty        <= width_hold;
                period      <= per_cnt;
                in_range    <= (width_hold >= DUTY_LO) && (width_hold <= DUTY_HI);
                locked      <= 1'b1;
                signal_lost <= 1'b0;
            end else if (timeout) begin
                locked      <= 1'b0;
                signal_lost <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
`timescale 1ns/1ps
module tb_pwm_capture;

    localparam int TD      = 4;
    localparam int DW      = 10;
    localparam int PW      = 12;
    localparam int TIMEOUT = 2048;
    localparam int DLO     = 52;
    localparam int DHI     = 102;

    logic          CLK = 1'b0;
    logic          CPU_RESETN;
    logic          pwm_in;
    logic [DW-1:0] duty;
    logic [PW-1:0] period;
    logic          valid, in_range, locked, signal_lost;

    pwm_capture #(
        .DUTYLOW(DLO), .DUTYHIGH(DHI), .DUTYWIDTH(DW), .PERWIDTH(PW),
        .TICK_DIV(TD), .TIMEOUT_TICKS(TIMEOUT)
    ) dut (
        .CLK(CLK), .CPU_RESETN(CPU_RESETN), .pwm_in(pwm_in),
        .duty(duty), .period(period), .valid(valid), .in_range(in_range),
        .locked(locked), .signal_lost(signal_lost)
    );

    always #5 CLK = ~CLK;

    // Cycle index since reset release; cycle n carries a tick when n%TD == TD-1.
    int cyc;
    always @(posedge CLK or negedge CPU_RESETN) begin
        if (!CPU_RESETN) cyc <= 0;
        else             cyc <= cyc + 1;
    end

    typedef struct { int c; int d; int p; int r; int lk; int ls; } vrec_t;
    vrec_t obs_q[$];
    vrec_t exp_q[$];
    int    nvalid = 0;
    int    width_err = 0;
    logic  prev_valid = 1'b0;

    always @(negedge CLK) begin
        if (valid === 1'b1) begin
            obs_q.push_back('{c: cyc, d: int'(duty), p: int'(period), r: int'(in_range),
                              lk: int'(locked), ls: int'(signal_lost)});
            nvalid++;
            if (prev_valid === 1'b1) width_err++;
        end
        prev_valid = valid;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pin driving; detection cycle of each edge = drive cycle + 2.
    int rise_det = 0;
    int fall_det = 0;

    task automatic set_pin(input logic v);
        if (v && !pwm_in) rise_det = cyc + 2;
        if (!v && pwm_in) fall_det = cyc + 2;
        pwm_in = v;
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_aligned();
        while (cyc % TD != 0) @(negedge CLK);
    endtask

    // Reference model: ticks falling strictly between detection cycles a and b.
    function automatic int ticks_upto(input int x);
        return (x < 0) ? 0 : (x + 1) / TD;
    endfunction

    function automatic int ticks_between(input int a, input int b);
        return ticks_upto(b - 1) - ticks_upto(a);
    endfunction

    function automatic int sat(input int v, input int w);
        int m;
        m = (1 << w) - 1;
        return (v > m) ? m : v;
    endfunction

    task automatic push_model(input int r_prev, input int f_prev, input int r_now);
        int d, p;
        d = sat(ticks_between(r_prev, f_prev), DW);
        p = sat(ticks_between(r_prev, r_now), PW);
        exp_q.push_back('{c: r_now + 1, d: d, p: p, r: ((d >= DLO) && (d <= DHI)) ? 1 : 0,
                          lk: 1, ls: 0});
    endtask

    task automatic drain(input string tag);
        vrec_t o, e;
        int    k;
        check($sformatf("%s valid count", tag), obs_q.size(), exp_q.size());
        k = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check($sformatf("%s[%0d] valid cycle", tag, k), o.c, e.c);
            check($sformatf("%s[%0d] duty", tag, k), o.d, e.d);
            check($sformatf("%s[%0d] period", tag, k), o.p, e.p);
            check($sformatf("%s[%0d] in_range", tag, k), o.r, e.r);
            check($sformatf("%s[%0d] locked", tag, k), o.lk, e.lk);
            check($sformatf("%s[%0d] signal_lost", tag, k), o.ls, e.ls);
            k++;
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_lost(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (signal_lost === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " duty"}, duty, 0);
        check({tag, " period"}, period, 0);
        check({tag, " valid"}, valid, 0);
        check({tag, " in_range"}, in_range, 0);
        check({tag, " locked"}, locked, 0);
        check({tag, " signal_lost"}, signal_lost, 0);
    endtask

    typedef struct { int hi; int lo; int d; int p; int r; } tv_t;
    tv_t tab[6];

    initial begin
        int at, r_prev, f_cur, hi, lo, n0;

        tab[0] = '{hi: 75,   lo: 952, d: 75,   p: 1027, r: 1};
        tab[1] = '{hi: 51,   lo: 976, d: 51,   p: 1027, r: 0};
        tab[2] = '{hi: 52,   lo: 975, d: 52,   p: 1027, r: 1};
        tab[3] = '{hi: 102,  lo: 925, d: 102,  p: 1027, r: 1};
        tab[4] = '{hi: 103,  lo: 924, d: 103,  p: 1027, r: 0};
        tab[5] = '{hi: 1100, lo: 900, d: 1023, p: 2000, r: 0};

        pwm_in     = 1'b0;
        CPU_RESETN = 1'b0;
        hold(3);
        check_zero("reset");
        CPU_RESETN = 1'b1;

        // Pin held low: loss declared after TIMEOUT ticks.
        wait_lost(9000, at);
        check("lost timing window", ((at >= TIMEOUT*TD - TD) && (at <= TIMEOUT*TD + TD)) ? 1 : 0, 1);
        check("lost locked", locked, 0);
        check("lost no valid", nvalid, 0);

        // Table: rise in IDLE ignored, fall arms, then each rise publishes the previous pulse.
        wait_aligned();
        set_pin(1'b1); hold(8);
        set_pin(1'b0); hold(8);
        for (int i = 0; i < 6; i++) begin
            set_pin(1'b1);
            if (i > 0)
                exp_q.push_back('{c: rise_det + 1, d: tab[i-1].d, p: tab[i-1].p, r: tab[i-1].r, lk: 1, ls: 0});
            hold(tab[i].hi * TD);
            set_pin(1'b0);
            hold(tab[i].lo * TD);
        end
        set_pin(1'b1);
        exp_q.push_back('{c: rise_det + 1, d: tab[5].d, p: tab[5].p, r: tab[5].r, lk: 1, ls: 0});
        hold(8);
        drain("table");

        // Stuck high: loss declared, measurement held.
        wait_lost(10000, at);
        check("stuck lost seen", (at >= 0) ? 1 : 0, 1);
        check("stuck locked", locked, 0);
        check("stuck duty held", duty, 1023);
        check("stuck period held", period, 2000);
        check("stuck in_range held", in_range, 0);
        hold(100);
        check("stuck lost persists", signal_lost, 1);

        // Resume: fall arms, rise/fall/rise gives the next valid.
        wait_aligned();
        set_pin(1'b0); hold(400);
        set_pin(1'b1); hold(300);
        set_pin(1'b0); hold(3808);
        check("resume lost before valid", signal_lost, 1);
        set_pin(1'b1);
        exp_q.push_back('{c: rise_det + 1, d: 75, p: 1027, r: 1, lk: 1, ls: 0});
        hold(8);
        drain("resume");

        // Reset during HIGH with pin high at release.
        hold(20);
        CPU_RESETN = 1'b0;
        #1;
        check_zero("midreset");
        hold(3);
        n0 = nvalid;
        CPU_RESETN = 1'b1;
        hold(40);
        set_pin(1'b0); hold(40);
        set_pin(1'b1); hold(240);
        set_pin(1'b0); hold(160);
        check("midreset no early valid", nvalid, n0);
        set_pin(1'b1);
        exp_q.push_back('{c: rise_det + 1, d: 60, p: 100, r: 1, lk: 1, ls: 0});
        hold(8);
        drain("midreset");

        // Random pulse train checked against the tick-counting model.
        r_prev = rise_det;
        for (int k = 0; k < 12; k++) begin
            hi = int'($urandom_range(1, 700));
            lo = int'($urandom_range(1, 700));
            hold(hi);
            set_pin(1'b0);
            f_cur = fall_det;
            hold(lo);
            set_pin(1'b1);
            push_model(r_prev, f_cur, rise_det);
            r_prev = rise_det;
        end
        hold(8);
        drain("random");

        check("valid one cycle wide", width_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
